// File: rtl/memory_stage_if.sv
// EX/MEM inputs, data-memory port, stall and MEM/WB outputs of the memory stage.
// master is the stage itself; slave is whatever surrounds it (pipeline + memory).
interface memory_stage_if #(parameter int WORD_W = 32);
    logic              m_valid;
    logic              m_dREN;
    logic              m_dWEN;
    logic              m_RegWrite;
    logic              m_halt;
    logic [1:0]        m_MemToReg;
    logic [4:0]        m_regWSEL;
    logic [WORD_W-1:0] m_port_o;
    logic [WORD_W-1:0] m_memstore;
    logic [WORD_W-1:0] m_pc4;
    logic [WORD_W-1:0] m_lui;

    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    logic              mem_stall;

    logic              w_valid;
    logic              w_RegWrite;
    logic [4:0]        w_regWSEL;
    logic [WORD_W-1:0] w_wdat;
    logic              w_halt;

    modport master (
        input  m_valid, m_dREN, m_dWEN, m_RegWrite, m_halt, m_MemToReg, m_regWSEL,
               m_port_o, m_memstore, m_pc4, m_lui, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               w_valid, w_RegWrite, w_regWSEL, w_wdat, w_halt
    );

    modport slave (
        output m_valid, m_dREN, m_dWEN, m_RegWrite, m_halt, m_MemToReg, m_regWSEL,
               m_port_o, m_memstore, m_pc4, m_lui, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               w_valid, w_RegWrite, w_regWSEL, w_wdat, w_halt
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: one outstanding data-memory access at a time, stalling upstream
// until dhit, then loading the MEM/WB register. A valid halt parks the stage until reset.
module memory_stage #(
    parameter int WORD_W = 32
) (
    input logic           CLK,
    input logic           RST,
    memory_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, HALTED} state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] data_q;
    logic              store_q;
    logic [WORD_W-1:0] load_buf;
    logic              mem_op;
    logic              wb_load;
    logic [WORD_W-1:0] wdat_nx;

    always_comb begin
        mem_op        = bus.m_valid & (bus.m_dREN | bus.m_dWEN);
        state_nx      = state;
        wb_load       = 1'b0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_nx = WAIT;
                end else begin
                    wb_load = 1'b1;
                    if (bus.m_valid & bus.m_halt) state_nx = HALTED;
                end
            end
            WAIT: begin
                // A store wins when both enables are set.
                bus.dmemREN   = ~store_q;
                bus.dmemWEN   = store_q;
                bus.dmemaddr  = addr_q;
                bus.dmemstore = data_q;
                if (bus.dhit) state_nx = DONE;
            end
            DONE: begin
                wb_load  = 1'b1;
                state_nx = (bus.m_valid & bus.m_halt) ? HALTED : IDLE;
            end
            default: state_nx = HALTED;
        endcase

        // Under reset the state is treated as IDLE for stall purposes.
        if (RST) bus.mem_stall = mem_op;
        else     bus.mem_stall = ((state == IDLE) & mem_op) | (state == WAIT);

        case (bus.m_MemToReg)
            2'b00:   wdat_nx = bus.m_port_o;
            2'b01:   wdat_nx = load_buf;
            2'b10:   wdat_nx = bus.m_pc4;
            default: wdat_nx = bus.m_lui;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            store_q        <= 1'b0;
            load_buf       <= '0;
            bus.w_valid    <= 1'b0;
            bus.w_RegWrite <= 1'b0;
            bus.w_regWSEL  <= '0;
            bus.w_wdat     <= '0;
            bus.w_halt     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mem_op) begin
                addr_q  <= {bus.m_port_o[WORD_W-1:2], 2'b00};
                data_q  <= bus.m_memstore;
                store_q <= bus.m_dWEN;
            end
            if (state == WAIT && bus.dhit && !store_q)
                load_buf <= bus.dmemload;
            if (wb_load) begin
                bus.w_valid    <= bus.m_valid;
                bus.w_RegWrite <= bus.m_RegWrite & bus.m_valid;
                bus.w_regWSEL  <= bus.m_regWSEL;
                bus.w_wdat     <= wdat_nx;
                bus.w_halt     <= bus.m_valid & bus.m_halt;
            end else if (state == HALTED) begin
                bus.w_valid    <= 1'b0;
                bus.w_RegWrite <= 1'b0;
                bus.w_halt     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized instruction
// streams checked against a transaction-level model of the stage.
module tb_memory_stage;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST;
    int   n_pass = 0;
    int   n_total = 0;

    memory_stage_if #(.WORD_W(W)) bus ();
    memory_stage #(.WORD_W(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid, dren, dwen, rw, halt;
        logic [1:0]  m2r;
        logic [4:0]  wsel;
        logic [31:0] port_o, memstore, pc4, lui;
    } instr_t;

    // model state and per-instruction expectations
    logic [31:0] mdl_buf;
    bit          mdl_halted;
    logic        e_valid, e_rw, e_halt;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdat, e_addr, e_store;
    int          e_stall, e_ren, e_wen;

    // observations from the last run_instr
    int          o_stall, o_ren, o_wen, o_cycles;
    logic [31:0] o_addr, o_store;
    bit          o_timeout;

    function automatic instr_t mk(logic valid, logic dren, logic dwen, logic rw, logic halt,
                                  logic [1:0] m2r, logic [4:0] wsel, logic [31:0] port_o,
                                  logic [31:0] memstore);
        instr_t i;
        i.valid = valid; i.dren = dren; i.dwen = dwen; i.rw = rw; i.halt = halt;
        i.m2r = m2r; i.wsel = wsel; i.port_o = port_o; i.memstore = memstore;
        i.pc4 = 32'h0000_4000 + {$urandom_range(0, 255), 2'b00};
        i.lui = {$urandom_range(0, 65535), 16'h0};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        int sel;
        sel = $urandom_range(0, 3);
        return mk(($urandom_range(0, 99) < 85), (sel == 0 || sel == 2), (sel == 1 || sel == 2),
                  1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom, $urandom);
    endfunction

    task automatic drive(input instr_t i);
        bus.m_valid = i.valid; bus.m_dREN = i.dren; bus.m_dWEN = i.dwen;
        bus.m_RegWrite = i.rw; bus.m_halt = i.halt; bus.m_MemToReg = i.m2r;
        bus.m_regWSEL = i.wsel; bus.m_port_o = i.port_o; bus.m_memstore = i.memstore;
        bus.m_pc4 = i.pc4; bus.m_lui = i.lui;
    endtask

    // Behavioural view: one instruction in, one MEM/WB update out; a memory op
    // costs one issue cycle plus hit_at waiting cycles plus one completion cycle.
    task automatic model(input instr_t i, input int hit_at, input logic [31:0] ld);
        bit memop;
        memop = i.valid && (i.dren || i.dwen);
        e_stall = 0; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        if (mdl_halted) begin
            e_valid = 0; e_rw = 0; e_halt = 1; e_wsel = 0; e_wdat = 0;
            return;
        end
        if (memop) begin
            e_stall = hit_at + 1;
            e_addr  = i.port_o & 32'hFFFF_FFFC;
            e_store = i.memstore;
            if (i.dwen) e_wen = hit_at;
            else begin e_ren = hit_at; mdl_buf = ld; end
        end
        case (i.m2r)
            2'd0: e_wdat = i.port_o;
            2'd1: e_wdat = mdl_buf;
            2'd2: e_wdat = i.pc4;
            default: e_wdat = i.lui;
        endcase
        e_valid = i.valid; e_rw = i.valid & i.rw; e_halt = i.valid & i.halt; e_wsel = i.wsel;
        mdl_halted = e_halt;
    endtask

    // Present one instruction at a negedge, hold it while stalled, act as the memory.
    // Returns at the negedge after the MEM/WB load edge.
    task automatic run_instr(input instr_t i, input int hit_at, input logic [31:0] ld,
                             input bit noise);
        bit stall, done;
        o_stall = 0; o_ren = 0; o_wen = 0; o_cycles = 0; o_addr = 0; o_store = 0;
        o_timeout = 0; done = 0;
        drive(i);
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.dmemREN || bus.dmemWEN) begin
                if (bus.dmemREN) o_ren++;
                if (bus.dmemWEN) o_wen++;
                o_addr = bus.dmemaddr; o_store = bus.dmemstore;
                bus.dhit = ((o_ren + o_wen) >= hit_at);
                bus.dmemload = bus.dhit ? ld : $urandom;
            end else begin
                bus.dhit = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.dmemload = $urandom;
            end
            stall = bus.mem_stall;
            if (stall) o_stall++;
            o_cycles++;
            @(posedge CLK);
            @(negedge CLK);
            if (!stall) begin done = 1; break; end
        end
        bus.dhit = 1'b0;
        o_timeout = !done;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; bus.m_valid = 1'b0; bus.dhit = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        mdl_buf = 0; mdl_halted = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; bus.dhit = 1'b0; bus.dmemload = 0;
        drive(mk(1, 1, 0, 1, 0, 2'd1, 5'd3, 32'h10, 32'h0));
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK); #1;
        n_total++; if (bus.w_valid !== 1'b0) $display("FAIL reset_w_valid got %b want 0", bus.w_valid); else n_pass++;
        n_total++; if (bus.w_RegWrite !== 1'b0) $display("FAIL reset_w_RegWrite got %b want 0", bus.w_RegWrite); else n_pass++;
        n_total++; if (bus.w_halt !== 1'b0) $display("FAIL reset_w_halt got %b want 0", bus.w_halt); else n_pass++;
        n_total++; if (bus.w_regWSEL !== 5'd0) $display("FAIL reset_w_regWSEL got %0d want 0", bus.w_regWSEL); else n_pass++;
        n_total++; if (bus.w_wdat !== 32'd0) $display("FAIL reset_w_wdat got %h want 0", bus.w_wdat); else n_pass++;
        n_total++; if ({bus.dmemREN, bus.dmemWEN} !== 2'b00) $display("FAIL reset_req got %b want 00", {bus.dmemREN, bus.dmemWEN}); else n_pass++;
        n_total++; if (bus.mem_stall !== 1'b1) $display("FAIL reset_stall_memop got %b want 1", bus.mem_stall); else n_pass++;
        drive(mk(1, 0, 0, 1, 0, 2'd0, 5'd3, 32'h10, 32'h0));
        #1;
        n_total++; if (bus.mem_stall !== 1'b0) $display("FAIL reset_stall_alu got %b want 0", bus.mem_stall); else n_pass++;
        RST = 1'b0; bus.m_valid = 1'b0;
        mdl_buf = 0; mdl_halted = 0;
    endtask

    task automatic test_alu();
        instr_t i;
        @(negedge CLK);
        i = mk(1, 0, 0, 1, 0, 2'd0, 5'd5, 32'h0000_1234, 32'h0);
        model(i, 1, 0);
        run_instr(i, 1, 0, 1);
        n_total++; if (o_stall !== 0) $display("FAIL alu_stall got %0d want 0", o_stall); else n_pass++;
        n_total++; if (o_cycles !== 1) $display("FAIL alu_cycles got %0d want 1", o_cycles); else n_pass++;
        n_total++; if (bus.w_valid !== 1'b1) $display("FAIL alu_w_valid got %b want 1", bus.w_valid); else n_pass++;
        n_total++; if (bus.w_wdat !== 32'h1234) $display("FAIL alu_w_wdat got %h want 00001234", bus.w_wdat); else n_pass++;
        n_total++; if (bus.w_regWSEL !== 5'd5) $display("FAIL alu_w_regWSEL got %0d want 5", bus.w_regWSEL); else n_pass++;
        n_total++; if (bus.w_RegWrite !== 1'b1) $display("FAIL alu_w_RegWrite got %b want 1", bus.w_RegWrite); else n_pass++;
    endtask

    task automatic test_load();
        instr_t i;
        i = mk(1, 1, 0, 1, 0, 2'd1, 5'd9, 32'h0000_0103, 32'h0);
        model(i, 3, 32'hDEAD_BEEF);
        run_instr(i, 3, 32'hDEAD_BEEF, 0);
        n_total++; if (o_addr !== 32'h100) $display("FAIL load_addr got %h want 00000100", o_addr); else n_pass++;
        n_total++; if (o_ren !== 3) $display("FAIL load_ren_cycles got %0d want 3", o_ren); else n_pass++;
        n_total++; if (o_wen !== 0) $display("FAIL load_wen_cycles got %0d want 0", o_wen); else n_pass++;
        n_total++; if (o_stall !== 4) $display("FAIL load_stall_cycles got %0d want 4", o_stall); else n_pass++;
        n_total++; if (bus.w_wdat !== 32'hDEAD_BEEF) $display("FAIL load_w_wdat got %h want deadbeef", bus.w_wdat); else n_pass++;
        n_total++; if (bus.w_regWSEL !== 5'd9) $display("FAIL load_w_regWSEL got %0d want 9", bus.w_regWSEL); else n_pass++;
    endtask

    task automatic test_store_both();
        instr_t i;
        i = mk(1, 1, 1, 0, 0, 2'd0, 5'd2, 32'h0000_2006, 32'hCAFE_0001);
        model(i, 1, 32'h5555_AAAA);
        run_instr(i, 1, 32'h5555_AAAA, 0);
        n_total++; if (o_wen !== 1) $display("FAIL store_wen_cycles got %0d want 1", o_wen); else n_pass++;
        n_total++; if (o_ren !== 0) $display("FAIL store_ren_cycles got %0d want 0", o_ren); else n_pass++;
        n_total++; if (o_store !== 32'hCAFE_0001) $display("FAIL store_data got %h want cafe0001", o_store); else n_pass++;
        n_total++; if (o_addr !== 32'h2004) $display("FAIL store_addr got %h want 00002004", o_addr); else n_pass++;
        n_total++; if (o_cycles !== 3) $display("FAIL store_cycles got %0d want 3", o_cycles); else n_pass++;
        n_total++; if (bus.w_RegWrite !== 1'b0) $display("FAIL store_w_RegWrite got %b want 0", bus.w_RegWrite); else n_pass++;
        // load_buf must still hold the earlier load data
        i = mk(1, 0, 0, 1, 0, 2'd1, 5'd4, 32'h0, 32'h0);
        model(i, 1, 0);
        run_instr(i, 1, 0, 0);
        n_total++; if (bus.w_wdat !== 32'hDEAD_BEEF) $display("FAIL store_keeps_load_buf got %h want deadbeef", bus.w_wdat); else n_pass++;
    endtask

    task automatic test_bubble();
        instr_t i;
        i = mk(0, 1, 0, 1, 1, 2'd0, 5'd7, 32'h44, 32'h0);
        model(i, 1, 0);
        run_instr(i, 1, 0, 1);
        n_total++; if (bus.w_valid !== 1'b0) $display("FAIL bubble_w_valid got %b want 0", bus.w_valid); else n_pass++;
        n_total++; if (bus.w_RegWrite !== 1'b0) $display("FAIL bubble_w_RegWrite got %b want 0", bus.w_RegWrite); else n_pass++;
        n_total++; if (bus.w_halt !== 1'b0) $display("FAIL bubble_w_halt got %b want 0", bus.w_halt); else n_pass++;
        n_total++; if (o_stall + o_ren !== 0) $display("FAIL bubble_stall_or_req got %0d want 0", o_stall + o_ren); else n_pass++;
    endtask

    task automatic test_random();
        instr_t i;
        int hit;
        logic [31:0] ld;
        for (int n = 0; n < 150; n++) begin
            i = rand_instr();
            hit = $urandom_range(1, 4);
            ld = $urandom;
            model(i, hit, ld);
            run_instr(i, hit, ld, 1);
            n_total++; if (o_timeout) $display("FAIL rnd%0d_timeout stall never dropped", n); else n_pass++;
            n_total++; if (o_stall !== e_stall) $display("FAIL rnd%0d_stall got %0d want %0d", n, o_stall, e_stall); else n_pass++;
            n_total++; if (o_ren !== e_ren || o_wen !== e_wen) $display("FAIL rnd%0d_req got ren %0d wen %0d want ren %0d wen %0d", n, o_ren, o_wen, e_ren, e_wen); else n_pass++;
            if (e_ren + e_wen > 0) begin
                n_total++; if (o_addr !== e_addr) $display("FAIL rnd%0d_addr got %h want %h", n, o_addr, e_addr); else n_pass++;
            end
            if (e_wen > 0) begin
                n_total++; if (o_store !== e_store) $display("FAIL rnd%0d_store got %h want %h", n, o_store, e_store); else n_pass++;
            end
            n_total++; if (bus.w_valid !== e_valid || bus.w_RegWrite !== e_rw || bus.w_halt !== e_halt) $display("FAIL rnd%0d_flags got v%b rw%b h%b want v%b rw%b h%b", n, bus.w_valid, bus.w_RegWrite, bus.w_halt, e_valid, e_rw, e_halt); else n_pass++;
            n_total++; if (bus.w_regWSEL !== e_wsel) $display("FAIL rnd%0d_wsel got %0d want %0d", n, bus.w_regWSEL, e_wsel); else n_pass++;
            n_total++; if (bus.w_wdat !== e_wdat) $display("FAIL rnd%0d_wdat got %h want %h", n, bus.w_wdat, e_wdat); else n_pass++;
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        drive(mk(1, 1, 0, 1, 0, 2'd1, 5'd6, 32'h0000_0208, 32'h0));
        #1;
        n_total++; if (bus.mem_stall !== 1'b1) $display("FAIL rstwait_issue_stall got %b want 1", bus.mem_stall); else n_pass++;
        @(posedge CLK); @(negedge CLK); #1;
        n_total++; if (bus.dmemREN !== 1'b1) $display("FAIL rstwait_ren got %b want 1", bus.dmemREN); else n_pass++;
        RST = 1'b1; bus.dhit = 1'b0;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0; #1;
        n_total++; if ({bus.dmemREN, bus.dmemWEN} !== 2'b00) $display("FAIL rstwait_req_after got %b want 00", {bus.dmemREN, bus.dmemWEN}); else n_pass++;
        n_total++; if (bus.mem_stall !== 1'b1) $display("FAIL rstwait_idle_stall got %b want 1", bus.mem_stall); else n_pass++;
        n_total++; if ({bus.w_valid, bus.w_RegWrite, bus.w_halt, bus.w_regWSEL, bus.w_wdat} !== '0) $display("FAIL rstwait_w_zero got v%b rw%b h%b s%0d d%h want all 0", bus.w_valid, bus.w_RegWrite, bus.w_halt, bus.w_regWSEL, bus.w_wdat); else n_pass++;
        // late dhit alongside an ALU op reading load_buf: must see 0
        drive(mk(1, 0, 0, 1, 0, 2'd1, 5'd6, 32'h0, 32'h0));
        bus.dhit = 1'b1; bus.dmemload = 32'h1234_5678;
        #1;
        n_total++; if (bus.mem_stall !== 1'b0) $display("FAIL rstwait_alu_stall got %b want 0", bus.mem_stall); else n_pass++;
        @(posedge CLK); @(negedge CLK);
        bus.dhit = 1'b0; #1;
        n_total++; if (bus.w_wdat !== 32'h0) $display("FAIL rstwait_load_buf got %h want 0", bus.w_wdat); else n_pass++;
        n_total++; if (bus.w_valid !== 1'b1) $display("FAIL rstwait_w_valid got %b want 1", bus.w_valid); else n_pass++;
    endtask

    task automatic test_halt();
        instr_t i;
        i = mk(1, 0, 0, 1, 1, 2'd0, 5'd1, 32'h77, 32'h0);
        model(i, 1, 0);
        run_instr(i, 1, 0, 0);
        n_total++; if (bus.w_halt !== 1'b1) $display("FAIL halt_w_halt got %b want 1", bus.w_halt); else n_pass++;
        n_total++; if (bus.w_valid !== e_valid) $display("FAIL halt_w_valid got %b want %b", bus.w_valid, e_valid); else n_pass++;
        for (int n = 0; n < 4; n++) begin
            i = mk(1, (n == 1), (n == 2), 1, 0, 2'd0, 5'd3, $urandom, $urandom);
            model(i, 1, 0);
            run_instr(i, 1, 32'hFFFF_0000, 1);
            n_total++; if (o_stall + o_ren + o_wen !== 0) $display("FAIL halted%0d_activity got stall %0d ren %0d wen %0d want 0", n, o_stall, o_ren, o_wen); else n_pass++;
            n_total++; if (bus.w_valid !== e_valid || bus.w_RegWrite !== e_rw) $display("FAIL halted%0d_w got v%b rw%b want v%b rw%b", n, bus.w_valid, bus.w_RegWrite, e_valid, e_rw); else n_pass++;
            n_total++; if (bus.w_halt !== e_halt) $display("FAIL halted%0d_sticky got %b want %b", n, bus.w_halt, e_halt); else n_pass++;
        end
        do_reset();
        #1;
        n_total++; if (bus.w_halt !== 1'b0) $display("FAIL halt_cleared_by_reset got %b want 0", bus.w_halt); else n_pass++;
    endtask

    initial begin
        mdl_buf = 0; mdl_halted = 0;
        test_reset();
        test_alu();
        test_load();
        test_store_both();
        test_bubble();
        test_random();
        test_reset_in_wait();
        @(negedge CLK);
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter WORD_W, default 32, datapath word width in bits.
REQ-002 SHALL have one clock and a synchronous active-high reset: CLK in 1, rising-edge clock; RST in 1, synchronous active-high reset.
REQ-003 SHALL have these upstream inputs from the EX/MEM latch:
- m_valid in 1, latch holds a real instruction.
- m_dREN in 1, load; m_dWEN in 1, store.
- m_RegWrite in 1; m_halt in 1.
- m_MemToReg in 2, writeback source select.
- m_regWSEL in 5, destination register.
- m_port_o in WORD_W, ALU result and memory address.
- m_memstore in WORD_W, store data.
- m_pc4 in WORD_W; m_lui in WORD_W.
REQ-004 SHALL have this data-memory port: dmemREN out 1; dmemWEN out 1; dmemaddr out WORD_W; dmemstore out WORD_W; dhit in 1, access complete; dmemload in WORD_W, load data valid with dhit.
REQ-005 SHALL have mem_stall out 1, which freezes all upstream latches while high.
REQ-006 SHALL have these MEM/WB outputs, all registered: w_valid out 1; w_RegWrite out 1; w_regWSEL out 5; w_wdat out WORD_W; w_halt out 1.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, DONE and HALTED.
REQ-008 SHALL define "mem op" as m_valid & (m_dREN | m_dWEN).
REQ-009 In IDLE with a mem op, SHALL on the same edge latch addr = {m_port_o[WORD_W-1:2], 2'b00}, store data, and request type, then go to WAIT.
REQ-010 In WAIT, SHALL drive dmemREN/dmemWEN and dmemaddr/dmemstore only from the registers latched in REQ-009; requests SHALL be 0 in every other state.
REQ-011 When m_dREN and m_dWEN are both set, SHALL treat the instruction as a store only (dmemWEN=1, dmemREN=0).
REQ-012 In WAIT with dhit=1, SHALL capture dmemload into load_buf (loads only) and go to DONE; with dhit=0 it SHALL remain in WAIT indefinitely.
REQ-013 SHALL drive mem_stall = (IDLE & mem op) | WAIT, combinationally; mem_stall SHALL be 0 in DONE and HALTED and for non-mem ops.
REQ-014 In DONE, SHALL load the MEM/WB registers from the still-held m_* inputs plus load_buf, then go to IDLE.
REQ-015 Minimum latency SHALL be: mem op with dhit on the first WAIT cycle takes 3 cycles (IDLE, WAIT, DONE); a non-mem instruction takes 1 cycle.
REQ-016 In IDLE with a non-mem op or a bubble, SHALL load the MEM/WB registers on the next edge with no stall.
REQ-017 Any bubble (m_valid=0) SHALL load w_valid=0 and w_RegWrite=0.
REQ-018 SHALL select w_wdat by m_MemToReg: 00 = m_port_o, 01 = load_buf, 10 = m_pc4, 11 = m_lui.
REQ-019 For a store, w_RegWrite SHALL equal m_RegWrite as supplied; the stage SHALL NOT override it.
REQ-020 w_RegWrite SHALL equal m_RegWrite & m_valid.
REQ-021 When a valid instruction with m_halt=1 loads into MEM/WB, SHALL set w_halt=1 and enter HALTED.
REQ-022 In HALTED:
- w_halt SHALL stay sticky at 1.
- w_valid and w_RegWrite SHALL be held at 0.
- No memory request SHALL be issued.
- mem_stall SHALL be 0.
- HALTED SHALL be left only by RST.
REQ-023 SHALL ignore dhit in IDLE, DONE and HALTED.

Reset
REQ-024 With RST=1 at a rising edge, the FSM SHALL go to IDLE and w_valid, w_RegWrite, w_halt, w_regWSEL, w_wdat, load_buf and the latched addr/data SHALL all be 0.
REQ-025 Reset asserted during WAIT SHALL abandon the access: dmemREN/dmemWEN SHALL be 0 from the first cycle after that edge, and a late dhit SHALL be ignored.
REQ-026 While RST=1, mem_stall SHALL still follow REQ-013 using state IDLE.

Verification
REQ-027 ALU op, m_port_o=0x0000_1234, MemToReg=00, RegWrite=1, regWSEL=5 -> one edge later w_valid=1, w_wdat=0x1234, w_regWSEL=5, mem_stall never high.
REQ-028 Load, m_port_o=0x0000_0103, dhit asserted on the 3rd WAIT cycle, dmemload=0xDEAD_BEEF -> dmemaddr=0x0000_0100, dmemREN high for exactly 3 cycles, mem_stall high for 4 cycles, then w_wdat=0xDEAD_BEEF.
REQ-029 Store with m_dREN=m_dWEN=1, m_memstore=0xCAFE_0001, dhit on the 1st WAIT cycle -> dmemWEN=1, dmemREN=0, dmemstore=0xCAFE_0001, total 3 cycles.
REQ-030 Valid halt instruction, then further valid ALU ops -> w_halt=1 sticky, w_valid=0 afterwards, no dmemREN/dmemWEN, until RST.
REQ-031 RST pulsed during WAIT of a load, dhit=1 in the following cycle -> requests 0 after the edge, state IDLE, w_* all 0, load_buf unchanged at 0.
REQ-032 Bubble (m_valid=0) with m_RegWrite=1 -> w_valid=0, w_RegWrite=0.
